iq_block_scaler: RTL and testbench

IQ_BLOCK_SCALER -- requirements
Module: iq_block_scaler

---
 rtl/iq_block_scaler.sv | 257 +++++++++++++++++++++++++
 tb/tb_iq_block_scaler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_block_scaler.sv
// IQ block floating-point scaler: ping-pong block buffers, per-block exponent.
// Define IQ_BLOCK_SCALER_ROUND_EN for round-half-up with saturation.
module iq_block_scaler #(
  parameter int IQ_WIDTH   = 16,
  parameter int OUT_WIDTH  = 12,
  parameter int BLOCK_SIZE = 1024,
  parameter int EXP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sync,
  input  logic [IQ_WIDTH-1:0]  in_i,
  input  logic [IQ_WIDTH-1:0]  in_q,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_i,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_sof,
  output logic                 drop
);

  localparam int AW   = $clog2(BLOCK_SIZE);
  localparam int SMAX = IQ_WIDTH - OUT_WIDTH;

  localparam logic [AW-1:0] LAST =
    AW'(BLOCK_SIZE - 1);
  localparam logic [IQ_WIDTH-1:0] POS_MAX =
    {1'b0, {(IQ_WIDTH-1){1'b1}}};
  localparam logic [IQ_WIDTH-1:0] NEG_MIN =
    {1'b1, {(IQ_WIDTH-1){1'b0}}};
  localparam logic [IQ_WIDTH-1:0] OUT_LIM =
    IQ_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } state_t;

  function automatic logic [IQ_WIDTH-1:0] absSat(
    input logic [IQ_WIDTH-1:0] x
  );
    logic [IQ_WIDTH-1:0] r;
    if (!x[IQ_WIDTH-1])
      r = x;
    else if (x == NEG_MIN)
      r = POS_MAX;
    else
      r = -x;
    return r;
  endfunction

  function automatic logic [EXP_WIDTH-1:0] blockExp(
    input logic [IQ_WIDTH-1:0] m
  );
    logic [EXP_WIDTH-1:0] e;
    e = EXP_WIDTH'(SMAX);
    for (int k = SMAX; k >= 0; k--)
      if ((m >> k) <= OUT_LIM)
        e = EXP_WIDTH'(k);
    return e;
  endfunction

`ifdef IQ_BLOCK_SCALER_ROUND_EN
  localparam logic signed [IQ_WIDTH:0] OMAX =
    (IQ_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IQ_WIDTH:0] OMIN = ~OMAX;

  // One guard bit keeps x + 2^(e-1) from wrapping.
  function automatic logic [OUT_WIDTH-1:0] scale(
    input logic [IQ_WIDTH-1:0]  x,
    input logic [EXP_WIDTH-1:0] e
  );
    logic signed [IQ_WIDTH:0] half;
    logic signed [IQ_WIDTH:0] sum;
    logic signed [IQ_WIDTH:0] sh;
    logic [OUT_WIDTH-1:0]     r;
    half = ((IQ_WIDTH+1)'(1) << e) >> 1;
    sum  = $signed({x[IQ_WIDTH-1], x}) + half;
    sh   = sum >>> e;
    if (sh > OMAX)
      r = OMAX[OUT_WIDTH-1:0];
    else if (sh < OMIN)
      r = OMIN[OUT_WIDTH-1:0];
    else
      r = sh[OUT_WIDTH-1:0];
    return r;
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] scale(
    input logic [IQ_WIDTH-1:0]  x,
    input logic [EXP_WIDTH-1:0] e
  );
    return OUT_WIDTH'($signed(x) >>> e);
  endfunction
`endif

  logic [IQ_WIDTH-1:0] memI [2*BLOCK_SIZE];
  logic [IQ_WIDTH-1:0] memQ [2*BLOCK_SIZE];

  logic                synced;
  logic                dropping;
  logic                wrBuf;
  logic [AW-1:0]       wrIdx;
  logic [IQ_WIDTH-1:0] maxAbs;
  logic [1:0]          full;
  logic [IQ_WIDTH-1:0] blkMax [2];

  logic [AW-1:0]       curIdx;
  logic [IQ_WIDTH-1:0] curMax;
  logic [IQ_WIDTH-1:0] absI;
  logic [IQ_WIDTH-1:0] absQ;
  logic [IQ_WIDTH-1:0] newMax;
  logic                accept;
  logic                dropNow;
  logic                wrEn;
  logic                blkDone;

  state_t              state;
  state_t              nextState;
  logic                rdBuf;
  logic [AW-1:0]       rdIdx;
  logic [AW-1:0]       rdAddr;
  logic                loadEn;
  logic                advance;
  logic                freeEn;
  logic [EXP_WIDTH-1:0] expNow;
  logic [EXP_WIDTH-1:0] eSel;
  logic [IQ_WIDTH-1:0] rdI;
  logic [IQ_WIDTH-1:0] rdQ;

  // A sync restarts the block, dropping any partial one.
  always_comb begin
    curIdx  = in_sync ? '0 : wrIdx;
    curMax  = in_sync ? '0 : maxAbs;
    absI    = absSat(in_i);
    absQ    = absSat(in_q);
    newMax  = curMax;
    if (absI > newMax)
      newMax = absI;
    if (absQ > newMax)
      newMax = absQ;
    accept  = in_valid && (synced || in_sync);
    dropNow = accept &&
      (full[wrBuf] || (dropping && !in_sync));
    wrEn    = accept && !dropNow;
    blkDone = wrEn && (curIdx == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      synced    <= 1'b0;
      dropping  <= 1'b0;
      wrBuf     <= 1'b0;
      wrIdx     <= '0;
      maxAbs    <= '0;
      full      <= '0;
      blkMax[0] <= '0;
      blkMax[1] <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= dropNow;
      if (in_valid && in_sync)
        synced <= 1'b1;
      if (accept && in_sync)
        dropping <= dropNow;
      else if (dropNow)
        dropping <= 1'b1;
      if (wrEn) begin
        if (blkDone) begin
          full[wrBuf]   <= 1'b1;
          blkMax[wrBuf] <= newMax;
          wrBuf         <= ~wrBuf;
          wrIdx         <= '0;
          maxAbs        <= '0;
        end else begin
          wrIdx  <= curIdx + 1'b1;
          maxAbs <= newMax;
        end
      end
      if (freeEn)
        full[rdBuf] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      memI[{wrBuf, curIdx}] <= in_i;
      memQ[{wrBuf, curIdx}] <= in_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Blocks complete in alternating buffers, so rdBuf is the oldest.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:
        if (full[rdBuf])
          nextState = LOAD;
      LOAD:
        nextState = DRAIN;
      DRAIN:
        if (out_ready && rdIdx == LAST)
          nextState = IDLE;
      default:
        nextState = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DRAIN);
    loadEn    = (state == LOAD);
    advance   = out_valid && out_ready;
    freeEn    = advance && (rdIdx == LAST);
    rdAddr    = loadEn ? '0 : rdIdx + 1'b1;
    expNow    = blockExp(blkMax[rdBuf]);
    eSel      = loadEn ? expNow : out_exp;
    rdI       = memI[{rdBuf, rdAddr}];
    rdQ       = memQ[{rdBuf, rdAddr}];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdBuf   <= 1'b0;
      rdIdx   <= '0;
      out_i   <= '0;
      out_q   <= '0;
      out_exp <= '0;
      out_sof <= 1'b0;
    end else if (loadEn) begin
      rdIdx   <= '0;
      out_exp <= expNow;
      out_sof <= 1'b1;
      out_i   <= scale(rdI, eSel);
      out_q   <= scale(rdQ, eSel);
    end else if (advance) begin
      out_sof <= 1'b0;
      if (rdIdx == LAST) begin
        rdBuf <= ~rdBuf;
      end else begin
        rdIdx <= rdAddr;
        out_i <= scale(rdI, eSel);
        out_q <= scale(rdQ, eSel);
      end
    end
  end

endmodule

// File: tb/tb_iq_block_scaler.sv
// Scoreboard bench for iq_block_scaler: random and directed blocks
// against an arithmetic reference of the block-exponent rules.
`timescale 1ns/1ps
module tb_iq_block_scaler;

  localparam int IW = 16;
  localparam int OW = 12;
  localparam int BS = 8;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sync = 1'b0;
  logic [IW-1:0] in_i = '0;
  logic [IW-1:0] in_q = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [OW-1:0] out_i;
  logic [OW-1:0] out_q;
  logic [EW-1:0] out_exp;
  logic          out_sof;
  logic          drop;

  typedef struct {
    logic [OW-1:0] i;
    logic [OW-1:0] q;
    logic [EW-1:0] e;
    logic          sof;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   dropCnt = 0;
  int   hsCnt = 0;
  int   readyCtl = 0;
  int   blkI[BS];
  int   blkQ[BS];

  always #5 clk = ~clk;

  iq_block_scaler #(
    .IQ_WIDTH  (IW),
    .OUT_WIDTH (OW),
    .BLOCK_SIZE(BS),
    .EXP_WIDTH (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_i     (in_i),
    .in_q     (in_q),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_exp  (out_exp),
    .out_sof  (out_sof),
    .drop     (drop)
  );

  task automatic check(input string name,
                       input longint act,
                       input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  function automatic int absSat(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic int refExp(input int m);
    for (int e = 0; e <= IW - OW; e++)
      if (m / (1 << e) <= 2047)
        return e;
    return IW - OW;
  endfunction

  function automatic int floorDiv(input int v, input int d);
    int r;
    r = v / d;
    if ((v % d) != 0 && v < 0)
      r = r - 1;
    return r;
  endfunction

  function automatic int scaleRef(input int v, input int e);
    int d;
    int r;
    d = 1 << e;
`ifdef IQ_BLOCK_SCALER_ROUND_EN
    if (e > 0)
      r = floorDiv(v + d / 2, d);
    else
      r = v;
    if (r > 2047)
      r = 2047;
    if (r < -2048)
      r = -2048;
`else
    r = floorDiv(v, d);
`endif
    return r;
  endfunction

  task automatic pushBlock();
    int   m;
    int   e;
    exp_t x;
    m = 0;
    for (int k = 0; k < BS; k++) begin
      if (absSat(blkI[k]) > m) m = absSat(blkI[k]);
      if (absSat(blkQ[k]) > m) m = absSat(blkQ[k]);
    end
    e = refExp(m);
    for (int k = 0; k < BS; k++) begin
      x.i   = OW'(scaleRef(blkI[k], e));
      x.q   = OW'(scaleRef(blkQ[k], e));
      x.e   = EW'(e);
      x.sof = (k == 0);
      sb.push_back(x);
    end
  endtask

  task automatic sendBlock(input int n,
                           input bit withSync,
                           input bit store,
                           input int gapPct);
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(0, 99) < gapPct) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_sync  = withSync && (k == 0);
      in_i     = IW'(blkI[k]);
      in_q     = IW'(blkQ[k]);
    end
    if (store)
      pushBlock();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic waitQueue(input int maxLeft,
                           input string name);
    int n;
    n = 0;
    while (sb.size() > maxLeft && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size() > maxLeft, 0);
  endtask

  task automatic fillConst(input int vi, input int vq);
    for (int k = 0; k < BS; k++) begin
      blkI[k] = vi;
      blkQ[k] = vq;
    end
  endtask

  task automatic fillRandom();
    int amp;
    amp = $urandom_range(0, 15);
    for (int k = 0; k < BS; k++) begin
      blkI[k] = $signed(16'($urandom)) >>> (15 - amp);
      blkQ[k] = $signed(16'($urandom)) >>> (15 - amp);
    end
    if ($urandom_range(0, 5) == 0)
      blkI[$urandom_range(0, BS - 1)] =
        $urandom_range(0, 1) ? -32768 : 32767;
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyCtl)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake.
  initial begin
    logic          stall;
    logic [OW-1:0] pi;
    logic [OW-1:0] pq;
    logic [EW-1:0] pe;
    logic          ps;
    exp_t          x;
    stall = 1'b0;
    pi = '0;
    pq = '0;
    pe = '0;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (drop)
        dropCnt++;
      if (stall && out_valid) begin
        check("hold_i", out_i, pi);
        check("hold_q", out_q, pq);
        check("hold_exp", out_exp, pe);
        check("hold_sof", out_sof, ps);
      end
      stall = out_valid && !out_ready;
      pi = out_i;
      pq = out_q;
      pe = out_exp;
      ps = out_sof;
      if (out_valid && out_ready) begin
        hsCnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got i=%0h expected none",
                   out_i);
        end else begin
          x = sb.pop_front();
          check("out_i", out_i, x.i);
          check("out_q", out_q, x.q);
          check("out_exp", out_exp, x.e);
          check("out_sof", out_sof, x.sof);
        end
      end
    end
  end

  initial begin
    int d0;
    int h0;
    int n;

    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sof", out_sof, 0);
    check("rst_drop", drop, 0);
    check("rst_i", out_i, 0);
    check("rst_q", out_q, 0);
    check("rst_exp", out_exp, 0);
    rst = 1'b1;
    readyCtl = 0;

    fillRandom();
    sendBlock(BS, 1'b0, 1'b0, 0);
    repeat (12) @(negedge clk);
    check("presync_drop", dropCnt, 0);
    check("presync_out", hsCnt, 0);

    fillConst(16'h0100, 16'h0100);
    sendBlock(BS, 1'b1, 1'b1, 0);
    @(negedge clk);
    check("lat_cycle0", out_valid, 0);
    @(negedge clk);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 1);
    waitQueue(0, "drain_const");

    fillConst(16'h0010, 16'h0010);
    blkI[0] = 16'h7FFF;
    blkI[3] = 16'h0018;
    sendBlock(BS, 1'b1, 1'b1, 0);
    waitQueue(0, "drain_max");

    fillConst(-5, 3);
    blkI[2] = -32768;
    sendBlock(BS, 1'b1, 1'b1, 0);
    waitQueue(0, "drain_min");

    fillRandom();
    sendBlock(5, 1'b1, 1'b0, 0);
    fillRandom();
    sendBlock(BS, 1'b1, 1'b1, 0);
    waitQueue(0, "drain_partial");

    readyCtl = 1;
    for (int b = 0; b < 24; b++) begin
      waitQueue(BS, "rand_space");
      fillRandom();
      sendBlock(BS, 1'b1, 1'b1, 25);
    end
    waitQueue(0, "drain_rand");

    readyCtl = 2;
    repeat (2) @(negedge clk);
    d0 = dropCnt;
    fillRandom();
    sendBlock(BS, 1'b1, 1'b1, 0);
    fillRandom();
    sendBlock(BS, 1'b1, 1'b1, 0);
    fillRandom();
    sendBlock(BS, 1'b1, 1'b0, 0);
    sendBlock(2, 1'b0, 1'b0, 0);
    repeat (6) @(negedge clk);
    check("ovf_drops", dropCnt - d0, BS + 2);
    check("ovf_queued", sb.size(), 2 * BS);
    check("ovf_valid", out_valid, 1);
    check("ovf_sof", out_sof, 1);
    readyCtl = 0;
    waitQueue(0, "drain_ovf");
    fillRandom();
    sendBlock(BS, 1'b1, 1'b1, 0);
    waitQueue(0, "drain_resync");

    readyCtl = 2;
    repeat (2) @(negedge clk);
    fillRandom();
    sendBlock(BS, 1'b1, 1'b1, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sof", out_sof, 0);
    sb.delete();
    readyCtl = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    h0 = hsCnt;
    d0 = dropCnt;
    fillRandom();
    sendBlock(BS, 1'b0, 1'b0, 0);
    repeat (20) @(negedge clk);
    check("post_rst_out", hsCnt - h0, 0);
    check("post_rst_drop", dropCnt - d0, 0);
    fillRandom();
    sendBlock(BS, 1'b1, 1'b1, 0);
    waitQueue(0, "drain_post_rst");
    check("post_rst_hs", hsCnt - h0, BS);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
